// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes, ALU codes, select encodings and the control bundle shared by decode_pipe.
// No ports; imported by decode_imm_gen and decode_pipe.
package decode_pkg;
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SRA = 6'b010101;
    localparam logic [2:0] ALU_BASE = 3'b000;
    localparam logic [2:0] ALU_ALT  = 3'b010;
    localparam logic [2:0] ALU_BR   = 3'b011;
    typedef enum logic [1:0] {OPA_RS1 = 2'b00, OPA_PC = 2'b01, OPA_ZERO = 2'b10} opa_e;
    typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_e;
    typedef struct packed {
        logic        wen;
        logic        mem_wen;
        logic        branch_op;
        logic        jal_op;
        logic        jalr_op;
        logic        illegal;
        opa_e        op_a_sel;
        logic        op_b_sel;
        logic [5:0]  alu_control;
        wb_e         wb_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm32;
    } ctrl_t;
    function automatic ctrl_t decode(input logic [31:0] instr, input logic [31:0] imm);
        ctrl_t c;
        logic [2:0] f3;
        logic alt;
        f3 = instr[14:12];
        alt = instr[31:25] == 7'b0100000;
        c = '0;
        c.rs1 = instr[19:15];
        c.rs2 = instr[24:20];
        c.rd = instr[11:7];
        c.imm32 = imm;
        case (instr[6:0])
            R_TYPE: begin c.wen = 1'b1; c.op_b_sel = 1'b1; c.alu_control = {alt ? ALU_ALT : ALU_BASE, f3}; end
            I_TYPE: begin c.wen = 1'b1; c.alu_control = (alt && f3 == 3'b101) ? ALU_SRA : {ALU_BASE, f3}; end
            LOAD:   begin c.wen = 1'b1; c.wb_sel = WB_MEM; c.alu_control = ALU_ADD; end
            STORE:  c.mem_wen = 1'b1;
            BRANCH: begin c.branch_op = 1'b1; c.op_b_sel = 1'b1; c.alu_control = {ALU_BR, f3}; end
            JAL:    begin c.wen = 1'b1; c.jal_op = 1'b1; c.wb_sel = WB_PC4; end
            JALR:   begin c.wen = 1'b1; c.jalr_op = 1'b1; c.wb_sel = WB_PC4; c.alu_control = ALU_ADD; end
            LUI:    begin c.wen = 1'b1; c.op_a_sel = OPA_ZERO; end
            AUIPC:  begin c.wen = 1'b1; c.op_a_sel = OPA_PC; end
            default: c.illegal = 1'b1;
        endcase
        // x0 is hardwired zero, so a write to it is never requested
        c.wen = c.wen && (c.rd != 5'd0);
        return c;
    endfunction
endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch-side and execute-side handshake plus decoded bundle of the decode stage.
// slave: decoder view (takes fetch inputs, drives execute outputs); master: the surrounding pipeline's view.
interface decode_pipe_if #(parameter int ADDRESS_BITS = 16);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDRESS_BITS-1:0] pc;
    logic [31:0]             instruction;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDRESS_BITS-1:0] out_pc;
    logic [4:0]              read_sel1;
    logic [4:0]              read_sel2;
    logic [4:0]              write_sel;
    logic                    wen;
    logic                    mem_wen;
    logic                    branch_op;
    logic                    jal_op;
    logic                    jalr_op;
    logic                    illegal;
    logic [31:0]             imm32;
    logic [1:0]              op_a_sel;
    logic                    op_b_sel;
    logic [5:0]              alu_control;
    logic [1:0]              wb_sel;
    logic [ADDRESS_BITS-1:0] target_pc;
    modport slave (
        input  in_valid, pc, instruction, flush, out_ready,
        output in_ready, out_valid, out_pc, read_sel1, read_sel2, write_sel, wen, mem_wen,
               branch_op, jal_op, jalr_op, illegal, imm32, op_a_sel, op_b_sel, alu_control,
               wb_sel, target_pc
    );
    modport master (
        output in_valid, pc, instruction, flush, out_ready,
        input  in_ready, out_valid, out_pc, read_sel1, read_sel2, write_sel, wen, mem_wen,
               branch_op, jal_op, jalr_op, illegal, imm32, op_a_sel, op_b_sel, alu_control,
               wb_sel, target_pc
    );
endinterface

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: combinational RV32I immediate builder (I/S/B/U/J chosen by opcode, 0 otherwise).
// i_instr: raw instruction; o_imm32: sign-extended immediate.
module decode_imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm32
);
    logic [6:0] w_op;
    assign w_op = i_instr[6:0];
    always_comb
        o_imm32 = (w_op == I_TYPE || w_op == LOAD || w_op == JALR) ? {{20{i_instr[31]}}, i_instr[31:20]} :
                  (w_op == STORE) ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
                  (w_op == BRANCH) ? {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                  (w_op == LUI || w_op == AUIPC) ? {i_instr[31:12], 12'd0} :
                  (w_op == JAL) ? {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                  32'd0;
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: registered, handshaked RV32I decode stage with one output register slice.
// Ports: clk, rst (async active-high), bus (decode_pipe_if.slave: fetch in, execute out, flush).
// Optional macro DECODE_PIPE_LOAD_INTERLOCK_EN adds a one-entry load-use scoreboard that
// inserts a single bubble; without it stall is tied low.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int ADDRESS_BITS   = 16,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input logic          clk,
    input logic          rst,
    decode_pipe_if.slave bus
);
    logic [31:0]             w_imm;
    ctrl_t                   w_dec;
    ctrl_t                   r_ctrl;
    logic                    w_adv;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_stall;
    logic                    r_valid;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic [ADDRESS_BITS-1:0] r_target;
    decode_imm_gen u_imm (.i_instr(bus.instruction), .o_imm32(w_imm));
    always_comb w_dec = decode(bus.instruction, w_imm);
    // the slot can take a new entry when empty or when execute consumes it this cycle
    assign w_adv    = !r_valid || bus.out_ready;
    assign bus.in_ready = w_adv && !w_stall && !bus.flush;
    assign w_accept = bus.in_valid && bus.in_ready;
    // accepted illegal instructions vanish unless they are to flow on as NOPs
    assign w_issue  = w_accept && (ILLEGAL_AS_NOP || !w_dec.illegal);
`ifdef DECODE_PIPE_LOAD_INTERLOCK_EN
    logic       r_sb_valid;
    logic [4:0] r_sb_rd;
    logic       w_uses_rs2;
    assign w_uses_rs2 = bus.instruction[6:0] == R_TYPE || bus.instruction[6:0] == STORE ||
                        bus.instruction[6:0] == BRANCH;
    assign w_stall = r_sb_valid && bus.in_valid &&
                     (w_dec.rs1 == r_sb_rd || (w_uses_rs2 && w_dec.rs2 == r_sb_rd));
    // the entry lives only while the load sits in the output slot; once the slot advances
    // (bubble or any other issue) the load is a full cycle ahead and the hazard is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_valid <= 1'b0;
            r_sb_rd <= 5'd0;
        end else if (bus.flush) begin
            r_sb_valid <= 1'b0;
        end else if (w_adv) begin
            r_sb_valid <= w_issue && bus.instruction[6:0] == LOAD && w_dec.rd != 5'd0;
            r_sb_rd <= w_dec.rd;
        end
    end
`else
    assign w_stall = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl <= '0;
            r_pc <= '0;
            r_target <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_ctrl <= w_dec;
                r_pc <= bus.pc;
                r_target <= bus.pc + w_imm[ADDRESS_BITS-1:0];
            end
        end
    end
    assign bus.out_valid   = r_valid;
    assign bus.out_pc      = r_pc;
    assign bus.target_pc   = r_target;
    assign bus.read_sel1   = r_ctrl.rs1;
    assign bus.read_sel2   = r_ctrl.rs2;
    assign bus.write_sel   = r_ctrl.rd;
    assign bus.wen         = r_ctrl.wen;
    assign bus.mem_wen     = r_ctrl.mem_wen;
    assign bus.branch_op   = r_ctrl.branch_op;
    assign bus.jal_op      = r_ctrl.jal_op;
    assign bus.jalr_op     = r_ctrl.jalr_op;
    assign bus.illegal     = r_ctrl.illegal;
    assign bus.imm32       = r_ctrl.imm32;
    assign bus.op_a_sel    = r_ctrl.op_a_sel;
    assign bus.op_b_sel    = r_ctrl.op_b_sel;
    assign bus.alu_control = r_ctrl.alu_control;
    assign bus.wb_sel      = r_ctrl.wb_sel;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed self-checking bench for decode_pipe with hand-computed expectations.
module tb_decode_pipe;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;
    int   bubbles;
    logic acc;
    decode_pipe_if #(.ADDRESS_BITS(16)) d_if ();
    decode_pipe #(.ADDRESS_BITS(16), .ILLEGAL_AS_NOP(1'b1)) dut (.clk(clk), .rst(rst), .bus(d_if.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic [15:0] p, input logic [31:0] ins);
        d_if.pc = p;
        d_if.instruction = ins;
        d_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        rst = 1'b1;
        d_if.in_valid = 1'b0;
        d_if.pc = '0;
        d_if.instruction = '0;
        d_if.flush = 1'b0;
        d_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", d_if.out_valid, 0);
        chk("rst_wen", d_if.wen, 0);
        chk("rst_imm32", d_if.imm32, 0);
        chk("rst_target", d_if.target_pc, 0);
        chk("rst_alu", d_if.alu_control, 0);
        chk("rst_wb_op_a", {d_if.wb_sel, d_if.op_a_sel}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", d_if.in_ready, 1);
        issue(16'h0010, 32'h00500093);
        chk("addi_valid", d_if.out_valid, 1);
        chk("addi_imm", d_if.imm32, 32'd5);
        chk("addi_alu", d_if.alu_control, 6'b000000);
        chk("addi_wen_rd_opb", {d_if.wen, d_if.write_sel, d_if.op_b_sel}, {1'b1, 5'd1, 1'b0});
        chk("addi_pc", d_if.out_pc, 16'h0010);
        issue(16'h0014, 32'h402081B3);
        chk("sub_alu", d_if.alu_control, 6'b010000);
        chk("sub_opb", d_if.op_b_sel, 1);
        chk("sub_sels", {d_if.read_sel1, d_if.read_sel2, d_if.write_sel}, {5'd1, 5'd2, 5'd3});
        issue(16'h0040, 32'hFE000EE3);
        chk("beq_branch_wen", {d_if.branch_op, d_if.wen}, 2'b10);
        chk("beq_imm", d_if.imm32, 32'hFFFFFFFC);
        chk("beq_target", d_if.target_pc, 16'h003C);
        chk("beq_alu", d_if.alu_control, 6'b011000);
        issue(16'h0020, 32'h008000EF);
        chk("jal_target", d_if.target_pc, 16'h0028);
        chk("jal_wb", d_if.wb_sel, 2'b10);
        chk("jal_op_wen", {d_if.jal_op, d_if.wen}, 2'b11);
        issue(16'hFFFC, 32'h008000EF);
        chk("jal_wrap_target", d_if.target_pc, 16'h0004);
        issue(16'h0030, 32'h0020A223);
        chk("sw_wen_memw", {d_if.wen, d_if.mem_wen}, 2'b01);
        chk("sw_imm", d_if.imm32, 32'd4);
        issue(16'h0034, 32'h12345237);
        chk("lui_opa", d_if.op_a_sel, 2'b10);
        chk("lui_imm", d_if.imm32, 32'h12345000);
        issue(16'h0038, 32'h4030D093);
        chk("srai_alu", d_if.alu_control, 6'b010101);
        issue(16'h003C, 32'h00000013);
        chk("x0_wen", {d_if.out_valid, d_if.wen}, 2'b10);
        // load-use: lw x2 then add x3,x2,x2 presented back to back
        d_if.pc = 16'h0090;
        d_if.instruction = 32'h0000A103;
        d_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_if.pc = 16'h0094;
        d_if.instruction = 32'h002101B3;
        lat = 0;
        bubbles = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) chk("lw_wb", d_if.wb_sel, 2'b01);
            if (!d_if.out_valid) bubbles++;
            if (d_if.out_valid && d_if.write_sel == 5'd3) lat = k;
            acc = d_if.in_valid && d_if.in_ready;
            @(posedge clk);
            #1;
            if (acc) d_if.in_valid = 1'b0;
        end
        d_if.in_valid = 1'b0;
`ifdef DECODE_PIPE_LOAD_INTERLOCK_EN
        chk("lu_latency", lat, 3);
        chk("lu_bubbles", bubbles, 1);
`else
        chk("lu_latency", lat, 2);
        chk("lu_bubbles", bubbles, 0);
`endif
        @(negedge clk);
        // backpressure: output must hold while execute is not ready
        d_if.out_ready = 1'b0;
        issue(16'h0050, 32'h00500093);
        chk("bp_valid", d_if.out_valid, 1);
        d_if.pc = 16'h0054;
        d_if.instruction = 32'h402081B3;
        d_if.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", d_if.in_ready, 0);
            chk("bp_hold", {d_if.out_valid, d_if.out_pc, d_if.imm32[15:0], 10'd0, d_if.alu_control},
                {1'b1, 16'h0050, 16'd5, 10'd0, 6'b000000});
            @(negedge clk);
        end
        d_if.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", d_if.in_ready, 1);
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_pc", d_if.out_pc, 16'h0054);
        chk("bp_next_alu", d_if.alu_control, 6'b010000);
        // flush wins over a same-cycle input
        d_if.pc = 16'h0060;
        d_if.instruction = 32'h008000EF;
        d_if.in_valid = 1'b1;
        d_if.flush = 1'b1;
        #1;
        chk("flush_in_ready", d_if.in_ready, 0);
        @(posedge clk);
        #1;
        d_if.flush = 1'b0;
        d_if.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", d_if.out_valid, 0);
        @(negedge clk);
        chk("flush_not_issued", d_if.out_valid, 0);
        issue(16'h0070, 32'h0000007F);
        chk("ill_valid_flag", {d_if.out_valid, d_if.illegal}, 2'b11);
        chk("ill_enables", {d_if.wen, d_if.mem_wen}, 2'b00);
        // reset while an instruction is in the output slot
        d_if.pc = 16'h0080;
        d_if.instruction = 32'h00500093;
        d_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", d_if.out_valid, 0);
        chk("midrst_pc", d_if.out_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_midrst_valid", d_if.out_valid, 0);
        chk("post_midrst_ready", d_if.in_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
